spinner_quad_decoder: RTL and testbench

Quadrature (AB) decoder for the spinner interface: converts a two-phase encoder signal, such as a 600-pulse encoder on USER_IN[1:0], into signed movement counts. It is the receive side of the spinner encoder pattern the core already drives into the game. It synchronizes and deglitches both phases, decodes direction, and optionally divides the count (for example 600→300 dps). Movement builds up in a saturating accumulator that the consumer reads and clears with a one-cycle handshake.

---
 rtl/spinner_quad_decoder.sv | 133 +++++++++++++
 tb/tb_spinner_quad_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spinner_quad_decoder.sv
// spinner_quad_decoder: synchronized, deglitched AB quadrature decoder with divider and saturating read-clear accumulator.
// Define QUAD_DEC_ERR_EN to enable illegal-transition reporting on err/err_cnt.
module spinner_quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8,
    parameter int DIV         = 2,
    parameter int CNT_W       = 12
) (
    input  logic                    clk_12m,
    input  logic                    reset,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    rd,
    output logic signed [CNT_W-1:0] delta,
    output logic                    delta_valid,
    output logic                    step,
    output logic                    dir,
    output logic                    err,
    output logic [7:0]              err_cnt
);
    localparam logic signed [3:0]       SDIV = 4'(DIV);
    localparam logic signed [CNT_W-1:0] AMAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] AMIN = -AMAX;

    logic [SYNC_STAGES-1:0] sa, sb;
    logic [1:0]             s_ab, cand, f_ab, prev_ab, pd;
    logic [7:0]             fcnt;
    logic                   held, f_stb, init, moved, up, dn, hit;
    logic signed [3:0]      sub, sub_n;
    logic signed [CNT_W-1:0] acc, acc_n;

    always_ff @(posedge clk_12m or posedge reset)
        if (reset) begin
            sa <= '0;
            sb <= '0;
        end else begin
            sa <= {sa[SYNC_STAGES-2:0], enc_a};
            sb <= {sb[SYNC_STAGES-2:0], enc_b};
        end

    assign s_ab = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};

    // f_ab updates on the cycle the candidate has been seen for FILT_LEN consecutive cycles
    always_ff @(posedge clk_12m or posedge reset)
        if (reset) begin
            cand  <= '0;
            fcnt  <= '0;
            held  <= 1'b0;
            f_ab  <= '0;
            f_stb <= 1'b0;
        end else begin
            f_stb <= 1'b0;
            if (s_ab != cand) begin
                cand <= s_ab;
                fcnt <= '0;
                held <= (FILT_LEN == 1);
                if (FILT_LEN == 1) begin
                    f_ab  <= s_ab;
                    f_stb <= 1'b1;
                end
            end else if (!held) begin
                fcnt <= fcnt + 8'd1;
                if (int'(fcnt) + 1 >= FILT_LEN - 1) begin
                    held  <= 1'b1;
                    f_ab  <= cand;
                    f_stb <= 1'b1;
                end
            end
        end

    // Gray position {b, a^b} makes +1 quarter-step a difference of 1 mod 4
    assign pd    = {f_ab[0], ^f_ab} - {prev_ab[0], ^prev_ab};
    assign moved = !init && (f_ab != prev_ab);
    assign up    = moved && (pd == 2'd1);
    assign dn    = moved && (pd == 2'd3);

    always_comb begin
        sub_n = up ? (sub < 4'sd0 ? 4'sd1 : sub + 4'sd1) :
                dn ? (sub > 4'sd0 ? -4'sd1 : sub - 4'sd1) : sub;
        hit   = (up || dn) && (sub_n == SDIV || sub_n == -SDIV);
        acc_n = !step ? acc :
                dir   ? (acc == AMAX ? acc : acc + CNT_W'(1)) :
                        (acc == AMIN ? acc : acc - CNT_W'(1));
    end

    always_ff @(posedge clk_12m or posedge reset)
        if (reset) begin
            init    <= 1'b1;
            prev_ab <= '0;
            sub     <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
        end else begin
            step <= hit;
            if (hit) dir <= up;
            sub <= hit ? 4'sd0 : sub_n;
            if (!init) prev_ab <= f_ab;
            else if (f_stb) begin
                prev_ab <= f_ab;
                init    <= 1'b0;
            end
        end

    always_ff @(posedge clk_12m or posedge reset)
        if (reset) begin
            acc         <= '0;
            delta       <= '0;
            delta_valid <= 1'b0;
        end else begin
            delta_valid <= rd;
            if (rd) begin
                delta <= acc_n;
                acc   <= '0;
            end else acc <= acc_n;
        end

`ifdef QUAD_DEC_ERR_EN
    logic bad;
    assign bad = moved && (pd == 2'd2);

    always_ff @(posedge clk_12m or posedge reset)
        if (reset) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= bad;
            if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
`else
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_spinner_quad_decoder.sv
// tb_spinner_quad_decoder: directed checks on three decoder builds (defaults, DIV=1, DIV=1 with CNT_W=4).
module tb_spinner_quad_decoder;
    logic clk_12m = 1'b0;
    logic reset   = 1'b1;
    logic [2:0] ea = '0, eb = '0, rdv = '0;
    logic [2:0] dv, st, dr, er;
    logic [7:0] ec [3];
    logic signed [11:0] d0, d1;
    logic signed [3:0]  d2;
    int sn [3] = '{0, 0, 0};
    int en [3] = '{0, 0, 0};
    int tests = 0, fails = 0;

    always #5 clk_12m = ~clk_12m;

    spinner_quad_decoder u0 (
        .clk_12m(clk_12m), .reset(reset), .enc_a(ea[0]), .enc_b(eb[0]), .rd(rdv[0]),
        .delta(d0), .delta_valid(dv[0]), .step(st[0]), .dir(dr[0]), .err(er[0]), .err_cnt(ec[0]));

    spinner_quad_decoder #(.DIV(1)) u1 (
        .clk_12m(clk_12m), .reset(reset), .enc_a(ea[1]), .enc_b(eb[1]), .rd(rdv[1]),
        .delta(d1), .delta_valid(dv[1]), .step(st[1]), .dir(dr[1]), .err(er[1]), .err_cnt(ec[1]));

    spinner_quad_decoder #(.DIV(1), .CNT_W(4)) u2 (
        .clk_12m(clk_12m), .reset(reset), .enc_a(ea[2]), .enc_b(eb[2]), .rd(rdv[2]),
        .delta(d2), .delta_valid(dv[2]), .step(st[2]), .dir(dr[2]), .err(er[2]), .err_cnt(ec[2]));

    always @(posedge clk_12m)
        for (int k = 0; k < 3; k++) begin
            if (st[k]) sn[k] <= sn[k] + 1;
            if (er[k]) en[k] <= en[k] + 1;
        end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int getd(input int k);
        case (k)
            0:       return int'(d0);
            1:       return int'(d1);
            default: return int'(d2);
        endcase
    endfunction

    task automatic drive(input int k, input logic [1:0] ab, input int hold);
        ea[k] = ab[1];
        eb[k] = ab[0];
        repeat (hold) @(negedge clk_12m);
    endtask

    task automatic read(input int k);
        rdv[k] = 1'b1;
        @(negedge clk_12m);
        rdv[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, n;
        logic [1:0] fwd [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [1:0] rev [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        repeat (3) @(negedge clk_12m);
        check("rst_delta", getd(0), 0);
        check("rst_dv", dv[0], 0);
        check("rst_step", st[0], 0);
        check("rst_dir", dr[0], 0);
        check("rst_err", er[0], 0);
        check("rst_errcnt", ec[0], 0);
        reset = 1'b0;
        repeat (20) @(negedge clk_12m);

        // forward, DIV=2
        for (int i = 0; i < 4; i++) drive(0, fwd[i], 20);
        check("fwd_steps", sn[0], 2);
        check("fwd_dir", dr[0], 1);
        check("fwd_dv_pre", dv[0], 0);
        read(0);
        check("fwd_delta", getd(0), 2);
        check("fwd_dv", dv[0], 1);
        @(negedge clk_12m);
        check("fwd_dv_pulse", dv[0], 0);

        // illegal jumps
        base = sn[0];
        drive(0, 2'b11, 20);
        check("ill_nostep", sn[0], base);
`ifdef QUAD_DEC_ERR_EN
        check("ill_err1", en[0], 1);
        check("ill_cnt1", ec[0], 1);
`else
        check("ill_err_off", en[0], 0);
        check("ill_cnt_off", ec[0], 0);
`endif
        for (int i = 1; i < 300; i++) drive(0, (i % 2) ? 2'b00 : 2'b11, 14);
        drive(0, 2'b00, 6);
        check("ill_nostep300", sn[0], base);
`ifdef QUAD_DEC_ERR_EN
        check("ill_err300", en[0], 300);
        check("ill_cnt_sat", ec[0], 255);
`else
        check("ill_cnt_off300", ec[0], 0);
`endif

        // reverse, DIV=1, back-to-back reads
        for (int i = 0; i < 8; i++) drive(1, rev[i % 4], 20);
        check("rev_steps", sn[1], 8);
        check("rev_dir", dr[1], 0);
        rdv[1] = 1'b1;
        @(negedge clk_12m);
        check("rev_delta", getd(1), -8);
        @(negedge clk_12m);
        rdv[1] = 1'b0;
        check("rev_delta2", getd(1), 0);
        check("rev_dv2", dv[1], 1);

        // 5-cycle glitch on A
        base = sn[1];
        drive(1, 2'b10, 5);
        drive(1, 2'b00, 30);
        check("glitch_step", sn[1], base);
        check("glitch_err", en[1], 0);
        read(1);
        check("glitch_delta", getd(1), 0);
        check("glitch_dv", dv[1], 1);

        // saturation at +7, then read in the same cycle as a step
        for (int i = 0; i < 12; i++) drive(2, fwd[i % 4], 20);
        check("sat_steps", sn[2], 12);
        read(2);
        check("sat_delta", getd(2), 7);
        for (int i = 0; i < 3; i++) drive(2, fwd[i], 20);
        drive(2, 2'b00, 0);
        n = 0;
        while (!st[2] && n < 40) begin
            @(negedge clk_12m);
            n++;
        end
        check("step_latency", n, 11);
        read(2);
        check("simul_delta", getd(2), 4);
        repeat (3) @(negedge clk_12m);
        read(2);
        check("simul_acc_clr", getd(2), 0);

        // reset after one quarter-step, DIV=2
        drive(0, 2'b10, 20);
        reset = 1'b1;
        repeat (3) @(negedge clk_12m);
        check("mid_rst_delta", getd(0), 0);
        check("mid_rst_dir", dr[0], 0);
        check("mid_rst_errcnt", ec[0], 0);
        check("mid_rst_step", st[0], 0);
        reset = 1'b0;
        base = sn[0];
        drive(0, 2'b10, 20);
        check("mid_init_nostep", sn[0], base);
        drive(0, 2'b11, 20);
        check("mid_q1_nostep", sn[0], base);
        drive(0, 2'b01, 20);
        check("mid_q2_step", sn[0], base + 1);
        check("mid_q2_dir", dr[0], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
